m_div_seq: RTL and testbench

M_DIV_SEQ -- requirements
Module: m_div_seq

---
 rtl/m_div_seq_if.sv | 25 ++
 rtl/m_div_seq.sv | 127 ++++++++++++
 tb/tb_m_div_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/m_div_seq_if.sv
// Divider request/result bundle.
// The master drives operands and start; the slave returns status and results.
interface m_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sign;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             div_zero;

   modport master (
      output start, sign, a, b,
      input  busy, done, quot, rem, div_zero
   );

   modport slave (
      input  start, sign, a, b,
      output busy, done, quot, rem, div_zero
   );
endinterface

// File: rtl/m_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes the result signs at the end.
module m_div_seq #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   m_div_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_part;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_divs;
   logic             r_qneg;
   logic             r_rneg;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dz;

   logic             w_accept;
   logic             w_bzero;
   logic             w_last;
   logic             w_busy;
   logic             w_done;
   logic [WIDTH-1:0] w_amag;
   logic [WIDTH-1:0] w_bmag;
   logic [WIDTH+1:0] w_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_geq;

   assign w_accept = bus.start &&
                     (r_state == S_IDLE || r_state == S_DONE);
   assign w_bzero  = (bus.b == '0);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   // Magnitudes; the most negative value maps onto itself as unsigned.
   assign w_amag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_bmag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   assign w_sh   = {r_part, r_q[WIDTH-1]};
   assign w_geq  = (w_sh >= {2'b00, r_divs});
   assign w_diff = w_sh[WIDTH:0] - {1'b0, r_divs};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and status outputs.
   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = w_bzero ? S_DONE : S_RUN;
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_last) w_next = S_FIX;
         end
         S_FIX: begin
            w_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (w_accept) w_next = w_bzero ? S_DONE : S_RUN;
            else          w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, division steps and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_part <= '0;
         r_q    <= '0;
         r_divs <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_part <= '0;
         r_q    <= w_amag;
         r_divs <= w_bmag;
         r_qneg <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         r_rneg <= bus.sign & bus.a[WIDTH-1];
         r_dz   <= 1'b0;
         if (w_bzero) begin
            r_quot <= '1;
            r_rem  <= bus.a;
            r_dz   <= 1'b1;
         end
      end else if (r_state == S_RUN) begin
         r_cnt  <= r_cnt + 1'b1;
         r_part <= w_geq ? w_diff : w_sh[WIDTH:0];
         r_q    <= {r_q[WIDTH-2:0], w_geq};
      end else if (r_state == S_FIX) begin
         r_quot <= r_qneg ? -r_q : r_q;
         r_rem  <= r_rneg ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
      end
   end

   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.quot     = r_quot;
   assign bus.rem      = r_rem;
   assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_m_div_seq.sv
// Directed bench for m_div_seq: vector table plus busy/back-to-back/reset
// sequences, with edge-accurate latency and busy-width checks.
module tb_m_div_seq;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   m_div_seq_if #(.WIDTH(32)) bus ();

   m_div_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t v[12];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is at a negedge. Issues one start, scrambles the operand
   // inputs after acceptance, and waits for done (bounded).
   task automatic run(input logic s, input logic [31:0] ai,
                      input logic [31:0] bi, output int lat,
                      output int bcnt, output logic [31:0] q,
                      output logic [31:0] r, output logic dz);
      bit got;
      bus.sign  = s;
      bus.a     = ai;
      bus.b     = bi;
      bus.start = 1'b1;
      lat  = 0;
      bcnt = 0;
      got  = 0;
      q    = '0;
      r    = '0;
      dz   = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(posedge clk);
         lat++;
         #1;
         bus.start = 1'b0;
         bus.a     = $urandom;
         bus.b     = $urandom;
         bus.sign  = ~s;
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            got = 1;
            q   = bus.quot;
            r   = bus.rem;
            dz  = bus.div_zero;
         end
      end
      if (!got) lat = -1;
   endtask

   int          lat;
   int          bc;
   int          ndone;
   logic [31:0] q;
   logic [31:0] r;
   logic        dz;

   initial begin
      checks = 0;
      errors = 0;
      v[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      v[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      v[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,
                32'h7FFFFFFC, 32'd1, 1'b0};
      v[3]  = '{1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
      v[4]  = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
      v[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0, 1'b0};
      v[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                32'd0, 32'h80000000, 1'b0};
      v[7]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
      v[8]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,
                32'd3, 32'hFFFFFFFF, 1'b0};
      v[9]  = '{1'b0, 32'h12345678, 32'd1000,
                32'd305419, 32'd896, 1'b0};
      v[10] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
      v[11] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};

      reset     = 1'b1;
      bus.start = 1'b1;
      bus.sign  = 1'b0;
      bus.a     = 32'd9;
      bus.b     = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_quot", bus.quot, 32'd0);
      chk("rst_rem", bus.rem, 32'd0);
      chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);

      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         run(v[i].s, v[i].a, v[i].b, lat, bc, q, r, dz);
         chk($sformatf("v%0d_quot", i), q, v[i].q);
         chk($sformatf("v%0d_rem", i), r, v[i].r);
         chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, v[i].dz});
         chk($sformatf("v%0d_lat", i), lat, v[i].dz ? 1 : 34);
         chk($sformatf("v%0d_busy", i), bc, v[i].dz ? 0 : 33);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), {31'd0, bus.done}, 32'd0);
      end

      bus.sign  = 1'b0;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      lat = 0;
      ndone = 0;
      for (int k = 0; k < 60 && ndone == 0; k++) begin
         @(posedge clk);
         lat++;
         #1;
         bus.start = (lat == 10);
         bus.a     = (lat == 10) ? 32'd9 : 32'd100;
         bus.b     = (lat == 10) ? 32'd3 : 32'd7;
         @(negedge clk);
         if (bus.done) ndone = 1;
      end
      chk("ign_quot", bus.quot, 32'd14);
      chk("ign_rem", bus.rem, 32'd2);
      chk("ign_lat", lat, 34);

      run(1'b0, 32'd9, 32'd3, lat, bc, q, r, dz);
      chk("b2b_quot", q, 32'd3);
      chk("b2b_rem", r, 32'd0);
      chk("b2b_lat", lat, 34);

      run(1'b0, 32'd5, 32'd0, lat, bc, q, r, dz);
      run(1'b0, 32'd100, 32'd7, lat, bc, q, r, dz);
      chk("seq_quot", q, 32'd14);
      chk("seq_dz", {31'd0, dz}, 32'd0);

      @(negedge clk);
      bus.sign  = 1'b1;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("run_busy", {31'd0, bus.busy}, 32'd1);
      chk("run_hold_q", bus.quot, 32'd14);
      chk("run_hold_r", bus.rem, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_quot", bus.quot, 32'd0);
      chk("abort_rem", bus.rem, 32'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("abort_nodone", ndone, 0);

      run(1'b0, 32'd100, 32'd7, lat, bc, q, r, dz);
      chk("post_quot", q, 32'd14);
      chk("post_rem", r, 32'd2);
      chk("post_lat", lat, 34);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
